// File: rtl/pwm_corriente.sv
// pwm_corriente: fixed-frequency current PWM with per-period soft-start ramp.
// Define PWM_COMPLEMENTO_EN to add the complementary PWM_N output with dead time.
module pwm_corriente #(
   parameter int PERIODO   = 1023,
   parameter int RAMP_STEP = 8,
   parameter int PRESCALER = 1
`ifdef PWM_COMPLEMENTO_EN
   ,
   parameter int TIEMPO_MUERTO = 4
`endif
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       Enable,
   input  logic [9:0] Referencia,
   output logic       PWM,
`ifdef PWM_COMPLEMENTO_EN
   output logic       PWM_N,
`endif
   output logic [9:0] Ciclo_Actual,
   output logic       Fin_Periodo,
   output logic       Estable
);

   localparam logic [9:0] PER    = 10'(PERIODO);
   localparam logic [9:0] PER_M1 = 10'(PERIODO - 1);
   localparam logic [9:0] STEP   = 10'(RAMP_STEP);
   localparam logic [7:0] PRE_M1 = 8'(PRESCALER - 1);

   typedef enum logic [1:0] {
      APAGADO,
      RAMPA,
      ESTABLE
   } estado_t;

   estado_t    estado, estado_n;
   logic [7:0] presc, presc_n;
   logic [9:0] cnt, cnt_n;
   logic [9:0] ciclo, ciclo_n;
   logic [9:0] obj, obj_n;
   logic [9:0] objetivo, ciclo_upd, dif;
   logic       tick, wrap;
   logic       cmp, cmp_n;
   logic       fin, fin_n;
   logic       est, est_n;

   assign tick     = presc == PRE_M1;
   assign wrap     = tick && (cnt == PER_M1);
   assign objetivo = (Referencia > PER) ? PER : Referencia;

   // Result always lies between ciclo and objetivo, so no wrap-around.
   always_comb begin
      dif       = '0;
      ciclo_upd = ciclo;
      if (ciclo < objetivo) begin
         dif       = objetivo - ciclo;
         ciclo_upd = ciclo + ((dif > STEP) ? STEP : dif);
      end else if (ciclo > objetivo) begin
         dif       = ciclo - objetivo;
         ciclo_upd = ciclo - ((dif > STEP) ? STEP : dif);
      end
   end

   always_comb begin
      estado_n = estado;
      presc_n  = presc;
      cnt_n    = cnt;
      ciclo_n  = ciclo;
      obj_n    = obj;
      fin_n    = 1'b0;
      unique case (estado)
         APAGADO: begin
            presc_n = '0;
            cnt_n   = '0;
            ciclo_n = '0;
            obj_n   = '0;
            if (Enable)
               estado_n = RAMPA;
         end
         RAMPA, ESTABLE: begin
            if (!Enable) begin
               estado_n = APAGADO;
               presc_n  = '0;
               cnt_n    = '0;
               ciclo_n  = '0;
               obj_n    = '0;
            end else begin
               presc_n = tick ? '0 : presc + 8'd1;
               if (tick)
                  cnt_n = wrap ? '0 : cnt + 10'd1;
               if (wrap) begin
                  fin_n   = 1'b1;
                  obj_n   = objetivo;
                  ciclo_n = ciclo_upd;
                  if (estado == RAMPA && ciclo_upd == objetivo)
                     estado_n = ESTABLE;
                  else if (estado == ESTABLE && ciclo != objetivo)
                     estado_n = RAMPA;
               end
            end
         end
         default: estado_n = APAGADO;
      endcase
      cmp_n = (estado != APAGADO) && (cnt_n < ciclo_n);
      est_n = (estado_n != APAGADO) && (ciclo_n == obj_n);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         estado <= APAGADO;
         presc  <= '0;
         cnt    <= '0;
         ciclo  <= '0;
         obj    <= '0;
         cmp    <= 1'b0;
         fin    <= 1'b0;
         est    <= 1'b0;
      end else begin
         estado <= estado_n;
         presc  <= presc_n;
         cnt    <= cnt_n;
         ciclo  <= ciclo_n;
         obj    <= obj_n;
         cmp    <= cmp_n;
         fin    <= fin_n;
         est    <= est_n;
      end
   end

   assign Ciclo_Actual = ciclo;
   assign Fin_Periodo  = fin;
   assign Estable      = est;

`ifdef PWM_COMPLEMENTO_EN
   localparam logic [15:0] TM = 16'(TIEMPO_MUERTO);

   logic [15:0] run, run_n;
   logic        on, pwm_d, pwmn_d, pwm_q, pwmn_q;

   // run counts how long the compare has held its value; a side may
   // only go high once the compare has been stable for TM clocks.
   always_comb begin
      on    = estado_n != APAGADO;
      run_n = '0;
      if (on && estado != APAGADO && cmp_n == cmp)
         run_n = (run == TM) ? run : run + 16'd1;
      pwm_d  = on && cmp_n && (run_n >= TM);
      pwmn_d = on && !cmp_n && (run_n >= TM);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         run    <= '0;
         pwm_q  <= 1'b0;
         pwmn_q <= 1'b0;
      end else begin
         run    <= run_n;
         pwm_q  <= pwm_d;
         pwmn_q <= pwmn_d;
      end
   end

   assign PWM   = pwm_q;
   assign PWM_N = pwmn_q;
`else
   assign PWM = cmp;
`endif

endmodule

// File: tb/tb_pwm_corriente.sv
// tb_pwm_corriente: directed + random stimulus against a period-level model.
// Define PWM_COMPLEMENTO_EN to also exercise PWM_N and dead time.
module tb_pwm_corriente;

   localparam int P  = 16;
   localparam int RS = 4;
`ifdef PWM_COMPLEMENTO_EN
   localparam int TMB = 2;
`else
   localparam int TMB = 0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       Enable = 1'b0;
   logic [9:0] Referencia = '0;
   logic       PWM;
   logic [9:0] Ciclo_Actual;
   logic       Fin_Periodo;
   logic       Estable;
`ifdef PWM_COMPLEMENTO_EN
   logic       PWM_N;
`endif

   int nchk = 0;
   int npass = 0;

   pwm_corriente #(
      .PERIODO(P),
      .RAMP_STEP(RS),
      .PRESCALER(1)
`ifdef PWM_COMPLEMENTO_EN
      ,
      .TIEMPO_MUERTO(TMB)
`endif
   ) dut (
      .clk(clk),
      .reset(reset),
      .Enable(Enable),
      .Referencia(Referencia),
      .PWM(PWM),
`ifdef PWM_COMPLEMENTO_EN
      .PWM_N(PWM_N),
`endif
      .Ciclo_Actual(Ciclo_Actual),
      .Fin_Periodo(Fin_Periodo),
      .Estable(Estable)
   );

   always #5 clk = ~clk;

   // Model: position inside the period, applied duty, sampled target,
   // and a short history of the ideal compare for dead-time checking.
   bit m_on;
   int m_pos, m_duty, m_obj;
   bit m_fin;
   bit hist[$];

   function automatic bit tail(input bit v);
      if (hist.size() < TMB + 1)
         return 1'b0;
      for (int i = 0; i <= TMB; i++)
         if (hist[hist.size() - 1 - i] != v)
            return 1'b0;
      return 1'b1;
   endfunction

   task automatic model_edge();
      int o;
      m_fin = 1'b0;
      if (reset || (m_on && !Enable)) begin
         m_on = 1'b0;
      end else if (!m_on) begin
         m_on = Enable;
      end else if (m_pos == P - 1) begin
         o = (Referencia > P) ? P : int'(Referencia);
         m_obj = o;
         if (m_duty < o)
            m_duty += ((o - m_duty) > RS) ? RS : (o - m_duty);
         else if (m_duty > o)
            m_duty -= ((m_duty - o) > RS) ? RS : (m_duty - o);
         m_pos = 0;
         m_fin = 1'b1;
      end else begin
         m_pos++;
      end
      if (!m_on) begin
         m_pos = 0;
         m_duty = 0;
         m_obj = 0;
         hist.delete();
      end else begin
         hist.push_back(m_pos < m_duty);
         if (hist.size() > TMB + 1)
            void'(hist.pop_front());
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      nchk++;
      assert (obs === exp) npass++;
      else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
   endtask

   task automatic check_all();
      chk("pwm", 32'(PWM), 32'(m_on && tail(1'b1)));
      chk("ciclo", 32'(Ciclo_Actual), 32'(m_duty));
      chk("fin", 32'(Fin_Periodo), 32'(m_fin));
      chk("estable", 32'(Estable), 32'(m_on && m_duty == m_obj));
`ifdef PWM_COMPLEMENTO_EN
      chk("pwm_n", 32'(PWM_N), 32'(m_on && tail(1'b0)));
      chk("overlap", 32'(PWM & PWM_N), 32'd0);
`endif
   endtask

   task automatic cyc();
      model_edge();
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic wait_fin(input int maxc);
      bit got;
      got = 1'b0;
      for (int i = 0; i < maxc && !got; i++) begin
         cyc();
         got = Fin_Periodo;
      end
      chk("fin_timeout", 32'(got), 32'd1);
   endtask

   task automatic period_count(output int hi, output int hin);
      hi = int'(PWM);
      hin = 0;
`ifdef PWM_COMPLEMENTO_EN
      hin = int'(PWM_N);
`endif
      repeat (P - 1) begin
         cyc();
         hi += int'(PWM);
`ifdef PWM_COMPLEMENTO_EN
         hin += int'(PWM_N);
`endif
      end
   endtask

   initial begin
      int hi, hin;

      // reset state
      repeat (2) cyc();
      reset = 1'b0;
      cyc();

      // ramp 4, 8, 10
      Enable = 1'b1;
      Referencia = 10'd10;
      wait_fin(40);
      chk("ramp10_a", 32'(Ciclo_Actual), 32'd4);
      chk("ramp10_a_est", 32'(Estable), 32'd0);
      wait_fin(40);
      chk("ramp10_b", 32'(Ciclo_Actual), 32'd8);
      wait_fin(40);
      chk("ramp10_c", 32'(Ciclo_Actual), 32'd10);
      chk("ramp10_est", 32'(Estable), 32'd1);
      wait_fin(40);
      period_count(hi, hin);
      chk("duty10_hi", 32'(hi), 32'(10 - TMB));

      // clamp at PERIODO
      Enable = 1'b0;
      cyc();
      Enable = 1'b1;
      Referencia = 10'd1023;
      wait_fin(40);
      chk("clamp_a", 32'(Ciclo_Actual), 32'd4);
      wait_fin(40);
      chk("clamp_b", 32'(Ciclo_Actual), 32'd8);
      wait_fin(40);
      chk("clamp_c", 32'(Ciclo_Actual), 32'd12);
      wait_fin(40);
      chk("clamp_d", 32'(Ciclo_Actual), 32'd16);
      chk("clamp_est", 32'(Estable), 32'd1);
      wait_fin(40);
      period_count(hi, hin);
      chk("clamp_hi", 32'(hi), 32'd16);

      // mid-period reference change
      Referencia = 10'd10;
      repeat (3) wait_fin(40);
      chk("steady10", 32'(Ciclo_Actual), 32'd10);
      repeat (5) cyc();
      Referencia = 10'd2;
      cyc();
      chk("hold10", 32'(Ciclo_Actual), 32'd10);
      wait_fin(40);
      chk("down_a", 32'(Ciclo_Actual), 32'd6);
      chk("down_a_est", 32'(Estable), 32'd0);
      wait_fin(40);
      chk("down_b", 32'(Ciclo_Actual), 32'd2);
      chk("down_b_est", 32'(Estable), 32'd1);

      // disable while PWM high, then re-enable
      Referencia = 10'd10;
      repeat (3) wait_fin(40);
      repeat (3) cyc();
      chk("pre_off_pwm", 32'(PWM), 32'd1);
      Enable = 1'b0;
      cyc();
      chk("off_pwm", 32'(PWM), 32'd0);
      chk("off_ciclo", 32'(Ciclo_Actual), 32'd0);
      Enable = 1'b1;
      wait_fin(40);
      chk("restart", 32'(Ciclo_Actual), 32'd4);

`ifdef PWM_COMPLEMENTO_EN
      // dead time at duty 8 and suppression at duty 1
      Referencia = 10'd8;
      repeat (3) wait_fin(40);
      period_count(hi, hin);
      chk("dt8_hi", 32'(hi), 32'(8 - TMB));
      chk("dt8_hin", 32'(hin), 32'(8 - TMB));
      Referencia = 10'd1;
      repeat (3) wait_fin(40);
      period_count(hi, hin);
      chk("dt1_hi", 32'(hi), 32'd0);
`endif

      // async reset mid-period at duty 8
      Referencia = 10'd8;
      repeat (3) wait_fin(40);
      repeat (5) cyc();
      chk("pre_rst_ciclo", 32'(Ciclo_Actual), 32'd8);
      chk("pre_rst_pwm", 32'(PWM), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      chk("arst_pwm", 32'(PWM), 32'd0);
      chk("arst_ciclo", 32'(Ciclo_Actual), 32'd0);
      chk("arst_fin", 32'(Fin_Periodo), 32'd0);
      chk("arst_est", 32'(Estable), 32'd0);
      repeat (2) cyc();
      reset = 1'b0;

      // random phase
      repeat (1500) begin
         if ($urandom_range(0, 15) == 0)
            Referencia = ($urandom_range(0, 1) == 1) ?
                         10'($urandom_range(0, 1023)) :
                         10'($urandom_range(0, 20));
         if (Enable ? ($urandom_range(0, 79) == 0)
                    : ($urandom_range(0, 5) == 0))
            Enable = ~Enable;
         cyc();
      end

      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

endmodule
